// File: rtl/rx_phase_if.sv
// Sample/decision bundle between the QPSK matched filter and rx_phase_ctrl.
// The filter side is the master; the phase controller is the slave.
interface rx_phase_if #(
  parameter int UPSAMPLE     = 4,
  parameter int SAMPLE_NBITS = 21
);
  localparam int PHASE_NBITS = $clog2(UPSAMPLE);

  logic                           enable;
  logic                           restart;
  logic signed [SAMPLE_NBITS-1:0] sample_in;
  logic [PHASE_NBITS-1:0]         phase_out;
  logic                           locked;
  logic                           busy;

  modport master (
    output enable, restart, sample_in,
    input  phase_out, locked, busy
  );

  modport slave (
    input  enable, restart, sample_in,
    output phase_out, locked, busy
  );
endinterface

// File: rtl/rx_phase_ctrl.sv
// Symbol-timing acquisition: per-phase |sample| energy over a window, argmax drives filter phase_in.
// Optional macro RX_PHASE_TRACK_EN: continuous re-acquisition after the first lock.
module rx_phase_ctrl #(
  parameter int UPSAMPLE     = 4,
  parameter int SAMPLE_NBITS = 21,
  parameter int NSYMB_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst,
  rx_phase_if.slave  bus
);
  localparam int PW        = $clog2(UPSAMPLE);
  localparam int MAG_NBITS = SAMPLE_NBITS - 1;
  localparam int ACC_NBITS = SAMPLE_NBITS - 1 + NSYMB_LOG2;
  localparam logic [PW-1:0]         CNT_LAST = PW'(UPSAMPLE - 1);
  localparam logic [NSYMB_LOG2-1:0] SYM_LAST = {NSYMB_LOG2{1'b1}};

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_ACC    = 2'd1,
    ST_DECIDE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // The most negative sample has no positive twin; clamp it to full scale.
  function automatic logic [MAG_NBITS-1:0] sat_abs(input logic signed [SAMPLE_NBITS-1:0] x);
    if (x[SAMPLE_NBITS-1] == 1'b0) begin
      sat_abs = x[MAG_NBITS-1:0];
    end else if (x[MAG_NBITS-1:0] == '0) begin
      sat_abs = {MAG_NBITS{1'b1}};
    end else begin
      sat_abs = MAG_NBITS'(-x);
    end
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         k_q, k_d;
  logic [PW-1:0]         best_q, best_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [NSYMB_LOG2-1:0] sym_q, sym_d;
  logic [ACC_NBITS-1:0]  acc_q [UPSAMPLE];
  logic [ACC_NBITS-1:0]  acc_d [UPSAMPLE];
  logic                  locked_q, locked_d;
  logic                  busy_q, busy_d;

  logic [MAG_NBITS-1:0]  mag_s;
  logic [ACC_NBITS-1:0]  mag_ext_s;
  logic                  better_s;
  logic [PW-1:0]         next_best_s;

  // Next-state, accumulator and decision logic.
  always_comb begin
    mag_s       = sat_abs(bus.sample_in);
    mag_ext_s   = {{NSYMB_LOG2{1'b0}}, mag_s};
    better_s    = (acc_q[k_q] > acc_q[best_q]);
    next_best_s = better_s ? k_q : best_q;

    // Counter free-runs on enable in every state to track the filter's phase counter.
    if (bus.enable) begin
      cnt_d = cnt_q + PW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    state_d  = state_q;
    sym_d    = sym_q;
    k_d      = k_q;
    best_d   = best_q;
    phase_d  = phase_q;
    locked_d = locked_q;
    busy_d   = busy_q;
    for (int i = 0; i < UPSAMPLE; i++) begin
      acc_d[i] = acc_q[i];
    end

    if (bus.restart) begin
      state_d  = ST_ALIGN;
      locked_d = 1'b0;
      busy_d   = 1'b1;
      for (int i = 0; i < UPSAMPLE; i++) begin
        acc_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_ALIGN: begin
          for (int i = 0; i < UPSAMPLE; i++) begin
            acc_d[i] = '0;
          end
          if (bus.enable && (cnt_q == CNT_LAST)) begin
            state_d = ST_ACC;
            sym_d   = '0;
          end else begin
            state_d = ST_ALIGN;
          end
        end

        ST_ACC: begin
          if (bus.enable) begin
            for (int i = 0; i < UPSAMPLE; i++) begin
              if (cnt_q == PW'(i)) begin
                acc_d[i] = acc_q[i] + mag_ext_s;
              end else begin
                acc_d[i] = acc_q[i];
              end
            end
            if (cnt_q == CNT_LAST) begin
              sym_d = sym_q + NSYMB_LOG2'(1);
              if (sym_q == SYM_LAST) begin
                state_d = ST_DECIDE;
                k_d     = '0;
                best_d  = '0;
              end else begin
                state_d = ST_ACC;
              end
            end else begin
              sym_d = sym_q;
            end
          end else begin
            state_d = ST_ACC;
          end
        end

        // Strict compare keeps the lowest index on ties; samples are dropped here.
        ST_DECIDE: begin
          best_d = next_best_s;
          k_d    = k_q + PW'(1);
          if (k_q == CNT_LAST) begin
            phase_d  = next_best_s;
            locked_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_LOCKED;
          end else begin
            state_d  = ST_DECIDE;
          end
        end

        ST_LOCKED: begin
`ifdef RX_PHASE_TRACK_EN
          state_d = ST_ALIGN;
`else
          state_d = ST_LOCKED;
`endif
        end

        default: begin
          state_d = ST_ALIGN;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_ALIGN;
      cnt_q    <= '0;
      k_q      <= '0;
      best_q   <= '0;
      phase_q  <= '0;
      sym_q    <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b1;
      for (int i = 0; i < UPSAMPLE; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      best_q   <= best_d;
      phase_q  <= phase_d;
      sym_q    <= sym_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      for (int i = 0; i < UPSAMPLE; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign bus.phase_out = phase_q;
  assign bus.locked    = locked_q;
  assign bus.busy      = busy_q;
endmodule
